// File: rtl/seg7_scan_driver_if.sv
// Bus bundle between a register-file read port and the 7-segment scan driver.
// The master side supplies the word, its load strobe and the display mode;
// the slave side (the driver) returns the pin-level outputs and status.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W     = 32
);
  logic [DATA_W-1:0]     data_in;
  logic                  load;
  logic                  hex_mode;
  logic [6:0]            segments;
  logic [NUM_DIGITS-1:0] digit_en;
  logic                  pending;
  logic                  frame_done;

  modport master (
    output data_in, load, hex_mode,
    input  segments, digit_en, pending, frame_done
  );

  modport slave (
    input  data_in, load, hex_mode,
    output segments, digit_en, pending, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed NUM_DIGITS-digit 7-segment driver. A loaded word waits in a
// pending register and is swapped into the displayed word only when the scan
// wraps back to digit 0, so a frame never mixes two words.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks digits above the
// highest non-zero nibble (digit 0 is always driven).
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W     = 32,
  parameter int SCAN_DIV   = 1000
) (
  input  logic              clk,
  input  logic              reset,
  seg7_scan_driver_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = NUM_DIGITS * 4;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [SW-1:0]         pend_word;
  logic [SW-1:0]         shown;
  logic                  pend_flag;
  logic                  frame_done_r;
  logic [6:0]            seg_r;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] en_r;
  logic [NUM_DIGITS-1:0] en_next;
  logic                  slot_end;
  logic                  boundary;
  logic [3:0]            nib;
  logic                  drive;

  // Segment pattern {g,f,e,d,c,b,a}, active low; letters only in hex mode.
  function automatic logic [6:0] seg_decode(input logic [3:0] n, input logic hex);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    if (!hex && n > 4'h9) s = 7'h7F;
    return s;
  endfunction

  assign slot_end = (presc == PRESC_LAST);
  assign boundary = slot_end && (idx == IDX_LAST);
  assign nib      = shown[{idx, 2'b00} +: 4];

  // Word bits beyond the last digit are not displayed.
  if (DATA_W > SW) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^bus.data_in[DATA_W-1:SW];
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [IW-1:0] top_digit;

  // Highest digit holding a non-zero nibble; stays 0 for an all-zero word.
  always_comb begin
    top_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (shown[i*4 +: 4] != 4'h0) top_digit = IW'(i);
    end
  end

  assign drive = (idx <= top_digit);
`else
  assign drive = 1'b1;
`endif

  // Pattern for the current slot; slot cycle 0 is kept dark to stop ghosting.
  always_comb begin
    seg_next = 7'h7F;
    en_next  = '1;
    if (presc != '0 && drive) begin
      seg_next     = seg_decode(nib, bus.hex_mode);
      en_next[idx] = 1'b0;
    end
  end

  // Slot prescaler and digit index; index wrap marks the frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc        <= '0;
      idx          <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= boundary;
      if (slot_end) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Pending/shown words; a load in the boundary cycle still wins the pending slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_word <= '0;
      pend_flag <= 1'b0;
      shown     <= '0;
    end else begin
      if (boundary && pend_flag) begin
        shown     <= pend_word;
        pend_flag <= 1'b0;
      end
      if (bus.load) begin
        pend_word <= bus.data_in[SW-1:0];
        pend_flag <= 1'b1;
      end
    end
  end

  // Registered pin outputs, one clock behind the scan state.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r <= 7'h7F;
      en_r  <= '1;
    end else begin
      seg_r <= seg_next;
      en_r  <= en_next;
    end
  end

  assign bus.segments   = seg_r;
  assign bus.digit_en   = en_r;
  assign bus.pending    = pend_flag;
  assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits and a 4-clock slot.
module tb_seg7_scan_driver;
  localparam int ND = 4;
  localparam int DW = 16;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [6:0]    fr_seg[ND];
  logic [ND-1:0] fr_en[ND];

  seg7_scan_driver_if #(.NUM_DIGITS(ND), .DATA_W(DW)) bus_i ();

  seg7_scan_driver #(.NUM_DIGITS(ND), .DATA_W(DW), .SCAN_DIV(SD)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_word(input logic [15:0] w);
    bus_i.data_in = w;
    bus_i.load    = 1'b1;
    step(1);
    bus_i.load    = 1'b0;
  endtask

  // Waits for frame_done, then samples each digit mid-slot of the new frame.
  task automatic read_frame();
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!bus_i.frame_done && n < 64);
    chk("frame_timeout", {31'd0, bus_i.frame_done}, 32'd1);
    step(1);
    chk("ghost_en", {28'd0, bus_i.digit_en}, 32'hF);
    chk("ghost_seg", {25'd0, bus_i.segments}, 32'h7F);
    for (int d = 0; d < ND; d++) begin
      step(d == 0 ? 1 : 4);
      fr_seg[d] = bus_i.segments;
      fr_en[d]  = bus_i.digit_en;
    end
  endtask

  // segs packed {d3,d2,d1,d0} x 7 bits, ens packed {d3,d2,d1,d0} x 4 bits.
  task automatic check_frame(input string name, input logic [27:0] segs, input logic [15:0] ens);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("%s_seg%0d", name, d), {25'd0, fr_seg[d]}, {25'd0, segs[d*7 +: 7]});
      chk($sformatf("%s_en%0d", name, d), {28'd0, fr_en[d]}, {28'd0, ens[d*4 +: 4]});
    end
  endtask

  // Holds reset, checks reset outputs, then counts clocks to the first frame_done.
  task automatic reset_and_count(input string name);
    int n;
    reset = 1'b1;
    step(3);
    chk({name, "_rst_seg"}, {25'd0, bus_i.segments}, 32'h7F);
    chk({name, "_rst_en"}, {28'd0, bus_i.digit_en}, 32'hF);
    chk({name, "_rst_pend"}, {31'd0, bus_i.pending}, 32'd0);
    chk({name, "_rst_fd"}, {31'd0, bus_i.frame_done}, 32'd0);
    reset = 1'b0;
    n = 0;
    do begin
      step(1);
      n++;
      if (n == 1) chk({name, "_first_blank"}, {28'd0, bus_i.digit_en}, 32'hF);
      if (n == 2) begin
        chk({name, "_d0_en"}, {28'd0, bus_i.digit_en}, 32'hE);
        chk({name, "_d0_seg"}, {25'd0, bus_i.segments}, 32'h40);
      end
    end while (!bus_i.frame_done && n < 64);
    chk({name, "_fd_latency"}, n, 32'd16);
  endtask

  initial begin
    bus_i.data_in  = '0;
    bus_i.load     = 1'b0;
    bus_i.hex_mode = 1'b1;

    // reset and first frame timing
    reset_and_count("init");

    // basic word
    load_word(16'h1234);
    chk("t2_pending", {31'd0, bus_i.pending}, 32'd1);
    read_frame();
    check_frame("t2a", {7'h79, 7'h24, 7'h30, 7'h19}, 16'h7BDE);
    chk("t2_pend_clr", {31'd0, bus_i.pending}, 32'd0);
    read_frame();
    check_frame("t2b", {7'h79, 7'h24, 7'h30, 7'h19}, 16'h7BDE);

    // mid-frame load: old word stays up until the boundary
    load_word(16'h5678);
    chk("t3_pending", {31'd0, bus_i.pending}, 32'd1);
    chk("t3_old_en", {28'd0, bus_i.digit_en}, 32'h7);
    chk("t3_old_seg", {25'd0, bus_i.segments}, 32'h79);
    read_frame();
    check_frame("t3", {7'h12, 7'h02, 7'h78, 7'h00}, 16'h7BDE);
    chk("t3_pend_clr", {31'd0, bus_i.pending}, 32'd0);

    // decimal vs hex mode on A/F nibbles
    bus_i.hex_mode = 1'b0;
    load_word(16'h00AF);
    read_frame();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    check_frame("t4dec", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 16'hFFDE);
`else
    check_frame("t4dec", {7'h40, 7'h40, 7'h7F, 7'h7F}, 16'h7BDE);
`endif
    bus_i.hex_mode = 1'b1;
    read_frame();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    check_frame("t4hex", {7'h7F, 7'h7F, 7'h08, 7'h0E}, 16'hFFDE);
`else
    check_frame("t4hex", {7'h40, 7'h40, 7'h08, 7'h0E}, 16'h7BDE);
`endif

    // load on the boundary edge: pending word moves to shown, new word pends
    bus_i.data_in = 16'h1111;
    bus_i.load    = 1'b1;
    step(1);
    bus_i.data_in = 16'h2222;
    step(1);
    bus_i.load    = 1'b0;
    chk("t5_fd", {31'd0, bus_i.frame_done}, 32'd1);
    chk("t5_pend_stays", {31'd0, bus_i.pending}, 32'd1);
    step(2);
    chk("t5_shown_en", {28'd0, bus_i.digit_en}, 32'hE);
    chk("t5_shown_seg", {25'd0, bus_i.segments}, 32'h79);
    load_word(16'h3333);
    load_word(16'h4321);
    chk("t5_pend_b2b", {31'd0, bus_i.pending}, 32'd1);
    read_frame();
    check_frame("t5", {7'h19, 7'h30, 7'h24, 7'h79}, 16'h7BDE);

    // leading-zero handling
    load_word(16'h0042);
    read_frame();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    check_frame("t6", {7'h7F, 7'h7F, 7'h19, 7'h24}, 16'hFFDE);
`else
    check_frame("t6", {7'h40, 7'h40, 7'h19, 7'h24}, 16'h7BDE);
`endif

    // reset mid-scan with a word pending: it is lost, scan restarts at digit 0
    load_word(16'h7777);
    step(3);
    reset_and_count("midrst");
    chk("midrst_pend", {31'd0, bus_i.pending}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
